// File: rtl/led_matrix_scan.sv
// HUB75 1/16-scan driver for a 32x32 panel.
// Generates the row/col pixel address for the upstream colour pipeline, and
// samples the six returned colour bits after PIPE_LAT cycles. It shifts each
// row pair into the panel, then latches it and shows it for ON_CYCLES.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   {red,green,blue}_{up,down} - colour bits for rows row / row+16
//   row, col                - pixel address requested from upstream
//   r1,g1,b1,r2,g2,b2       - panel data lines
//   addr, pclk, lat, oe_n   - panel row address, shift clock, latch, enable
//   frame_done              - one-cycle pulse in the latch cycle of row 15
module led_matrix_scan #(
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned ON_CYCLES = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red_up,
  input  logic       green_up,
  input  logic       blue_up,
  input  logic       red_down,
  input  logic       green_down,
  input  logic       blue_down,
  output logic [3:0] row,
  output logic [4:0] col,
  output logic       r1,
  output logic       g1,
  output logic       b1,
  output logic       r2,
  output logic       g2,
  output logic       b2,
  output logic [3:0] addr,
  output logic       pclk,
  output logic       lat,
  output logic       oe_n,
  output logic       frame_done
);

  localparam int unsigned SUB_W  = 3;
  localparam int unsigned DISP_W = 16;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PIPE_LAT);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(ON_CYCLES - 1);
  localparam logic [4:0]        COL_LAST  = 5'd31;
  localparam logic [3:0]        ROW_LAST  = 4'd15;

  typedef enum logic [2:0] {
    SETUP   = 3'd0,
    DATA    = 3'd1,
    CLKH    = 3'd2,
    BLANK   = 3'd3,
    LATCH   = 3'd4,
    DISPLAY = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              run_q, run_d;
  logic [3:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [3:0]        addr_q, addr_d;
  logic [5:0]        rgb_q, rgb_d;
  logic              pclk_q, pclk_d;
  logic              lat_q, lat_d;
  logic              oe_n_q, oe_n_d;
  logic              frame_done_q, frame_done_d;

  // Next-state and next-output logic; strobes default to their idle level so
  // each output register mirrors the state being entered.
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    disp_d       = disp_q;
    run_d        = run_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    rgb_d        = rgb_q;
    pclk_d       = 1'b0;
    lat_d        = 1'b0;
    oe_n_d       = 1'b1;
    frame_done_d = 1'b0;

    unique case (state_q)
      SETUP: begin
        // The first edge after reset release only starts the scan, so that
        // edge counts as the first SETUP cycle rather than the reset interval.
        if (!run_q) begin
          run_d = 1'b1;
        end else if (sub_q == SUB_LAST) begin
          sub_d   = '0;
          state_d = DATA;
          rgb_d   = {red_up, green_up, blue_up, red_down, green_down, blue_down};
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      DATA: begin
        state_d = CLKH;
        pclk_d  = 1'b1;
      end
      CLKH: begin
        if (col_q == COL_LAST) begin
          state_d = BLANK;
        end else begin
          col_d   = col_q + 5'd1;
          state_d = SETUP;
        end
      end
      BLANK: begin
        state_d      = LATCH;
        addr_d       = row_q;
        lat_d        = 1'b1;
        frame_done_d = (row_q == ROW_LAST);
      end
      LATCH: begin
        state_d = DISPLAY;
        disp_d  = '0;
        oe_n_d  = 1'b0;
      end
      DISPLAY: begin
        if (disp_q == DISP_LAST) begin
          state_d = SETUP;
          row_d   = row_q + 4'd1;
          col_d   = '0;
        end else begin
          disp_d = disp_q + DISP_W'(1);
          oe_n_d = 1'b0;
        end
      end
      default: begin
        state_d = SETUP;
        sub_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SETUP;
      sub_q        <= '0;
      disp_q       <= '0;
      run_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      rgb_q        <= '0;
      pclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      disp_q       <= disp_d;
      run_q        <= run_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      rgb_q        <= rgb_d;
      pclk_q       <= pclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign {r1, g1, b1, r2, g2, b2} = rgb_q;
  assign addr       = addr_q;
  assign pclk       = pclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: four instances with different PIPE_LAT/ON_CYCLES
// share one clock and reset. Each instance is fed from a colour table through a
// PIPE_LAT-deep register pipe. Its outputs are compared every cycle against a
// timing model that works out the expected values from the cycle number since
// reset release.
module tb_led_matrix_scan;

  localparam int NI = 4;
  localparam int PL   [NI] = '{2, 0, 4, 2};
  localparam int ONC  [NI] = '{512, 7, 20, 1};
  localparam int ROWP [NI] = '{674, 105, 246, 163};
  localparam int FRAME0    = 10784;
  localparam int MID_T     = 26385;  // frame 2, row 7, col 19, pclk high (inst 0)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] lut [16][32];

  wire [3:0] row_w  [NI];
  wire [4:0] col_w  [NI];
  wire [5:0] dat_w  [NI];
  wire [3:0] addr_w [NI];
  wire       pclk_w [NI];
  wire       lat_w  [NI];
  wire       oen_w  [NI];
  wire       fd_w   [NI];

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned P = PL[g];
    localparam int unsigned ON = ONC[g];
    logic [5:0] pipe [8];
    wire  [5:0] cin;
    wire        o_r1, o_g1, o_b1, o_r2, o_g2, o_b2;

    always @(posedge clk) begin
      pipe[0] <= lut[row_w[g]][col_w[g]];
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end

    if (P == 0) begin : g_comb
      assign cin = lut[row_w[g]][col_w[g]];
    end else begin : g_reg
      assign cin = pipe[P-1];
    end

    led_matrix_scan #(.PIPE_LAT(P), .ON_CYCLES(ON)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .red_up     (cin[5]),
      .green_up   (cin[4]),
      .blue_up    (cin[3]),
      .red_down   (cin[2]),
      .green_down (cin[1]),
      .blue_down  (cin[0]),
      .row        (row_w[g]),
      .col        (col_w[g]),
      .r1         (o_r1),
      .g1         (o_g1),
      .b1         (o_b1),
      .r2         (o_r2),
      .g2         (o_g2),
      .b2         (o_b2),
      .addr       (addr_w[g]),
      .pclk       (pclk_w[g]),
      .lat        (lat_w[g]),
      .oe_n       (oen_w[g]),
      .frame_done (fd_w[g])
    );

    assign dat_w[g] = {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2};
  end

  // Expected {row,col,data,addr,pclk,lat,oe_n,frame_done} at cycle t after release.
  function automatic logic [22:0] model(input int p, input int on, input int t);
    int s, k, r, ri, w, pix, ph, prow;
    logic [5:0] d;
    logic [3:0] a;
    logic [4:0] c;
    logic pc, la, oe, fd;
    s    = p + 3;
    k    = 32 * s;
    r    = k + 2 + on;
    ri   = (t / r) % 16;
    w    = t % r;
    prow = (ri + 15) % 16;
    a    = (t < r) ? 4'd0 : 4'(prow);
    pc = 1'b0; la = 1'b0; oe = 1'b1; fd = 1'b0;
    if (w < k) begin
      pix = w / s;
      ph  = w % s;
      c   = 5'(pix);
      pc  = (ph == s - 1);
      if (ph >= p + 1)  d = lut[ri][pix];
      else if (pix > 0) d = lut[ri][pix-1];
      else if (t < r)   d = 6'd0;
      else              d = lut[prow][31];
    end else begin
      c  = 5'd31;
      d  = lut[ri][31];
      if (w >= k + 1) a = 4'(ri);
      la = (w == k + 1);
      oe = (w < k + 2);
      fd = la && (ri == 15);
    end
    return {4'(ri), c, d, a, pc, la, oe, fd};
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;
  int pc_cnt [NI];
  int last_lat [NI];
  int oe_run [NI];
  logic prev_pclk [NI];
  logic prev_oe [NI];
  logic [3:0] prev_addr [NI];
  int last_fd;
  int fd_cnt;

  // Single compare process: reset values while reset is high (also right after
  // an asynchronous assertion), otherwise the model plus event-level checks.
  always begin
    logic [22:0] exp_v, act_v;
    @(negedge clk or posedge reset);
    #1;
    for (int g = 0; g < NI; g++) begin
      act_v = {row_w[g], col_w[g], dat_w[g], addr_w[g], pclk_w[g], lat_w[g], oen_w[g], fd_w[g]};
      if (reset) begin
        exp_v = {4'd0, 5'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_chk++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL reset_values inst%0d time=%0t got=%h want=%h", g, $time, act_v, exp_v);
        end
        pc_cnt[g] = 0; last_lat[g] = -1; oe_run[g] = 0;
        prev_pclk[g] = 1'b0; prev_oe[g] = 1'b1; prev_addr[g] = 4'd0;
      end else begin
        exp_v = model(PL[g], ONC[g], t);
        n_chk++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL scan_model inst%0d t=%0d got=%h want=%h (row,col,rgb,addr,pclk,lat,oe_n,fd)",
                   g, t, act_v, exp_v);
        end
        if (pclk_w[g] && !prev_pclk[g]) pc_cnt[g]++;
        if (lat_w[g]) begin
          n_chk++;
          if (pc_cnt[g] != 32) begin
            n_fail++;
            $display("FAIL pclk_per_row inst%0d t=%0d got=%0d want=32", g, t, pc_cnt[g]);
          end
          pc_cnt[g] = 0;
          if (last_lat[g] >= 0) begin
            n_chk++;
            if (t - last_lat[g] != ROWP[g]) begin
              n_fail++;
              $display("FAIL row_period inst%0d t=%0d got=%0d want=%0d", g, t, t - last_lat[g], ROWP[g]);
            end
          end
          last_lat[g] = t;
        end
        if (!oen_w[g]) begin
          oe_run[g]++;
        end else if (!prev_oe[g]) begin
          n_chk++;
          if (oe_run[g] != ONC[g]) begin
            n_fail++;
            $display("FAIL oe_low_len inst%0d t=%0d got=%0d want=%0d", g, t, oe_run[g], ONC[g]);
          end
          oe_run[g] = 0;
        end
        if (addr_w[g] != prev_addr[g]) begin
          n_chk++;
          if (!(oen_w[g] && prev_oe[g])) begin
            n_fail++;
            $display("FAIL addr_while_lit inst%0d t=%0d got oe_n=%b/%b want 1/1", g, t, prev_oe[g], oen_w[g]);
          end
        end
        prev_pclk[g] = pclk_w[g];
        prev_oe[g]   = oen_w[g];
        prev_addr[g] = addr_w[g];
      end
    end
    if (reset) begin
      t = 0; last_fd = -1; fd_cnt = 0;
    end else begin
      if (fd_w[0]) begin
        fd_cnt++;
        if (last_fd >= 0) begin
          n_chk++;
          if (t - last_fd != FRAME0) begin
            n_fail++;
            $display("FAIL frame_spacing t=%0d got=%0d want=%0d", t, t - last_fd, FRAME0);
          end
        end
        last_fd = t;
      end
      // Hand-computed pins on the default instance.
      if (t <= 4) begin
        n_chk++;
        if (col_w[0] != 5'd0 || pclk_w[0] != (t == 4)) begin
          n_fail++;
          $display("FAIL startup t=%0d got col=%0d pclk=%b want col=0 pclk=%b", t, col_w[0], pclk_w[0], t == 4);
        end
      end
      if (t == MID_T) begin
        n_chk++;
        if (row_w[0] != 4'd7 || col_w[0] != 5'd19 || !pclk_w[0] || fd_cnt != 2) begin
          n_fail++;
          $display("FAIL mid_point got row=%0d col=%0d pclk=%b frames=%0d want 7 19 1 2",
                   row_w[0], col_w[0], pclk_w[0], fd_cnt);
        end
      end
      t++;
    end
  end

  initial begin
    int guard;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 32; c++) begin
        logic [3:0] rr;
        logic [4:0] cc;
        rr = 4'(r);
        cc = 5'(c);
        lut[r][c] = {rr[0], cc[0], cc[1], rr[1], cc[2], cc[4]};
      end
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;

    // Run two full frames, then stop in the middle of shifting row 7, col 19.
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (t != MID_T + 1 && guard < 40000);
    reset = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        lut[r][c] = 6'($urandom);
    repeat ($urandom_range(4, 20)) @(negedge clk);
    #2 reset = 1'b0;
    repeat (12000) @(negedge clk);

    // A second reset at a random point, with fresh random colours.
    repeat ($urandom_range(100, 3000)) @(negedge clk);
    #2 reset = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        lut[r][c] = 6'($urandom);
    repeat ($urandom_range(4, 12)) @(negedge clk);
    #2 reset = 1'b0;
    repeat (2000) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
